keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Input-side counterpart of the lock's indicator outputs: scans a 4x4 matrix keypad, debounces it and
//  emits one clean key event per press to the code-entry logic of the six-digit lock controller.
//  Drives rows active-low, reads pulled-up columns active-low, rejects bounce and multi-key presses.
// PARAMETERS
//  SCAN_DIV       1000  clk cycles each row is driven; frame = 4*SCAN_DIV cycles (min 2)
//  DEBOUNCE_SCANS 4     consecutive identical frames needed to accept a press or a release (min 1)
//  REPEAT_DELAY   32    frames held before first auto-repeat (KEYPAD_REPEAT_EN only)
//  REPEAT_RATE    8     frames between further auto-repeats (KEYPAD_REPEAT_EN only)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  col_in     in   4  keypad columns, active-low, externally pulled up; synchronised internally (2 FF)
//  row_out    out  4  keypad rows, exactly one bit low at any time
//  key_code   out  4  {row[1:0],col[1:0]} of accepted key; held until next accepted key
//  key_valid  out  1  one-cycle pulse per accepted key event
//  key_held   out  1  high while an accepted key remains pressed
// BEHAVIOUR
//  - Reset: row_out=4'b1110, key_code=0, key_valid=0, key_held=0, all counters 0, state IDLE.
//  - Divider counts 0..SCAN_DIV-1; at count SCAN_DIV-1 (tick) the synchronised col_in is sampled for the
//    current row, then row advances 0->1->2->3->0 (row_out 1110->1101->1011->0111->1110).
//  - Tick on row 3 closes a frame. Frame result: NONE (no low col), ONE(code) (exactly one low bit in
//    whole frame), MULTI (two or more low bits, any rows).
//  - Stability counter: reset to 1 when result differs from previous frame, else increments, saturating.
//  - FSM IDLE: stability reaches DEBOUNCE_SCANS with ONE(code) -> latch key_code, key_valid=1 on the
//    cycle after that frame-closing tick, key_held=1, go HELD. NONE/MULTI: stay IDLE, no output.
//  - FSM HELD: DEBOUNCE_SCANS consecutive NONE frames -> key_held=0 on the cycle after closing tick, IDLE.
//    ONE(other code) or MULTI: treated as still pressed, no new pulse, key_code unchanged.
//  - Min press-to-pulse latency: DEBOUNCE_SCANS frames + 1 cycle, measured from frame start.
//  - key_valid never asserts on two consecutive cycles; never asserts in the reset cycle.
//  - Reset mid-scan/debounce/hold: aborts immediately, no pulse, returns to reset values next cycle.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_DELAY frames since acceptance, additional key_valid
//    pulse (same key_code) every REPEAT_RATE frames, each on the cycle after a frame-closing tick.
//  Undefined: exactly one key_valid per press; REPEAT_* parameters ignored, no repeat counter built.
// STRUCTURE
//  lock_pkg: key code constants (KEY_0..KEY_9, KEY_STAR, KEY_HASH mapped onto {row,col}), frame-result
//    encoding (RES_NONE, RES_ONE, RES_MULTI), FSM state encoding (ST_IDLE, ST_HELD).
//  Sub-module key_debounce: stability counter + IDLE/HELD FSM + optional repeat; top keeps divider,
//    row driver, column synchroniser and frame accumulation.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_DELAY=8, REPEAT_RATE=4; frame=16 cycles)
//  1 Reset held 5 cycles -> row_out=1110, key_code=0, key_valid=0, key_held=0; then rows rotate every 4 cycles.
//  2 col_in=1101 whenever row_out=1011 from frame start -> single key_valid with key_code=4'h9 one cycle
//    after 3rd frame close (cycle 48, +2 sync); key_held=1.
//  3 Same key present 2 frames, absent 1, present 2, released -> no key_valid, key_held stays 0.
//  4 col_in=1100 on row 0 (two keys) for 6 frames -> no key_valid; change to 1110 -> pulse key_code=4'h0.
//  5 Hold 4'h9 for 20 frames, release 3 frames, macro undefined -> exactly one pulse; key_held falls
//    one cycle after 3rd NONE frame close. Macro defined -> pulses at accept, +8, +12, +16 frames.
//  6 rst pulsed during 2nd debounce frame of a press -> no key_valid; after release scan restarts at row 0.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared constants for the 4x4 keypad scanner: key codes {row,col}, frame-result
// encoding and debounce FSM state encoding.
package keypad_scanner_pkg;

  // Telephone layout: row 0 = 1 2 3 A, row 1 = 4 5 6 B, row 2 = 7 8 9 C, row 3 = * 0 # D
  localparam logic [3:0] KEY_1    = 4'h0;
  localparam logic [3:0] KEY_2    = 4'h1;
  localparam logic [3:0] KEY_3    = 4'h2;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h8;
  localparam logic [3:0] KEY_8    = 4'h9;
  localparam logic [3:0] KEY_9    = 4'hA;
  localparam logic [3:0] KEY_STAR = 4'hC;
  localparam logic [3:0] KEY_0    = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;

  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_ONE   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  function automatic logic [3:0] make_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event bus from the keypad scanner to the code-entry logic, plus FSM state for observation.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  // key_valid is a one-cycle event strobe with no ready: the consumer must take key_code on
  // the cycle key_valid is high; key_code stays stable until the next event.
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [0:0] state;

  modport master (output key_code, key_valid, key_held, state);
  modport slave  (input  key_code, key_valid, key_held, state);

endinterface

// File: rtl/keypad_scanner_debounce.sv
// Frame-level debouncer: stability counter and IDLE/HELD FSM. Auto-repeat is built only when
// KEYPAD_REPEAT_EN is defined.
module keypad_scanner_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_done,
  input  logic [1:0] frame_res,
  input  logic [3:0] frame_code,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [0:0] state
);

  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

  logic [STAB_W-1:0] stab, stab_nxt;
  logic [1:0]        prev_res;
  logic [3:0]        prev_code;
  logic              same, stable;

  always_comb begin
    same     = (frame_res == prev_res) && ((frame_res != RES_ONE) || (frame_code == prev_code));
    stab_nxt = !same ? STAB_W'(1) : ((stab == STAB_MAX) ? stab : stab + STAB_W'(1));
    stable   = (stab_nxt == STAB_MAX);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  logic [REP_W-1:0] rep_cnt;
  logic             rep_fire;
  assign rep_fire = ((rep_cnt + REP_W'(1)) == REP_W'(REPEAT_DELAY));
`else
  localparam int repeat_cfg_unused = REPEAT_DELAY + REPEAT_RATE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      stab      <= '0;
      prev_res  <= RES_NONE;
      prev_code <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        stab      <= stab_nxt;
        prev_res  <= frame_res;
        prev_code <= frame_code;
        case (state)
          ST_IDLE: begin
            if (stable && (frame_res == RES_ONE)) begin
              key_code  <= frame_code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt   <= '0;
`endif
            end
          end
          default: begin
            // Other keys or multi-presses while held count as "still pressed".
            if (stable && (frame_res == RES_NONE)) begin
              key_held <= 1'b0;
              state    <= ST_IDLE;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_fire) begin
              rep_cnt   <= REP_W'(REPEAT_DELAY - REPEAT_RATE);
              key_valid <= (frame_res != RES_NONE);
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row driver, column synchroniser and frame accumulation; debounce
// lives in keypad_scanner_debounce. Optional auto-repeat: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  keypad_scanner_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick, frame_done;
  logic [1:0]       row, lo_col, acc_n, acc_nxt, frame_res;
  logic [3:0]       col_s1, col_s2, col_low, acc_code, code_nxt;
  logic [2:0]       n_low, tot;

  always_comb begin
    tick    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    row_out = ~(4'b0001 << row);
    col_low = ~col_s2;
    n_low   = 3'(col_low[0]) + 3'(col_low[1]) + 3'(col_low[2]) + 3'(col_low[3]);
    tot     = {1'b0, acc_n} + n_low;
    // Low-bit count saturates at 2: anything beyond that is MULTI anyway.
    acc_nxt = (tot > 3'd2) ? 2'd2 : tot[1:0];
    casez (col_low)
      4'b???1: lo_col = 2'd0;
      4'b??10: lo_col = 2'd1;
      4'b?100: lo_col = 2'd2;
      default: lo_col = 2'd3;
    endcase
    code_nxt   = (acc_n == 2'd0) ? make_code(row, lo_col) : acc_code;
    frame_done = tick && (row == 2'd3);
    case (acc_nxt)
      2'd0:    frame_res = RES_NONE;
      2'd1:    frame_res = RES_ONE;
      default: frame_res = RES_MULTI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      row      <= 2'd0;
      col_s1   <= 4'hF;
      col_s2   <= 4'hF;
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
      if (tick) begin
        div_cnt  <= '0;
        row      <= row + 2'd1;
        acc_n    <= (row == 2'd3) ? 2'd0 : acc_nxt;
        acc_code <= code_nxt;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  keypad_scanner_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .frame_res  (frame_res),
    .frame_code (code_nxt),
    .key_code   (kp.key_code),
    .key_valid  (kp.key_valid),
    .key_held   (kp.key_held),
    .state      (kp.state)
  );

endmodule
